// File: rtl/sort4_engine_pkg.sv
// -----------------------------------------------------------------------------
// sort4_engine_pkg
// Shared definitions for the four-element compare/swap sorter:
//   - state_t   : sorter state encoding (IDLE / SORT / DONE)
//   - STEP_LAST : index of the final compare/swap step
//   - pair_lo() : step -> lower register index of the pair to compare
//                 (the upper index is always pair_lo + 1)
// No ports (package).
// -----------------------------------------------------------------------------
package sort4_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] STEP_LAST = 3'd5;

  // Bubble-sort schedule for four elements: three passes of shrinking length.
  // (0,1) (1,2) (2,3) | (0,1) (1,2) | (0,1)
  function automatic logic [1:0] pair_lo(input logic [2:0] step);
    logic [1:0] idx;
    case (step)
      3'd0:    idx = 2'd0;
      3'd1:    idx = 2'd1;
      3'd2:    idx = 2'd2;
      3'd3:    idx = 2'd0;
      3'd4:    idx = 2'd1;
      3'd5:    idx = 2'd0;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sort4_engine_if.sv
// -----------------------------------------------------------------------------
// sort4_engine_if
// Request/result bundle of the sorter.
//   start        : request a sort (sampled on the rising clock edge)
//   signed_mode  : 1 = two's-complement ordering, 0 = unsigned ordering
//   x0..x3       : operands, latched when the request is accepted
//   s0..s3       : sorted result, s0 smallest (registered)
//   busy         : high while compare/swap steps are running
//   done         : one-cycle pulse when s0..s3 hold the final result
// Modports: master (requester) and slave (sorter).
// -----------------------------------------------------------------------------
interface sort4_engine_if #(
  parameter int N = 6
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] x0;
  logic [N-1:0] x1;
  logic [N-1:0] x2;
  logic [N-1:0] x3;
  logic [N-1:0] s0;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] s3;
  logic         busy;
  logic         done;

  modport master (
    output start, signed_mode, x0, x1, x2, x3,
    input  s0, s1, s2, s3, busy, done
  );

  modport slave (
    input  start, signed_mode, x0, x1, x2, x3,
    output s0, s1, s2, s3, busy, done
  );
endinterface

// File: rtl/sort4_engine_cmp_swap.sv
// -----------------------------------------------------------------------------
// sort4_engine_cmp_swap
// Combinational compare-and-swap of one operand pair.
//   i_a, i_b       : pair in current register order
//   i_signed_mode  : 1 = two's-complement compare, 0 = unsigned compare
//   o_lo, o_hi     : pair in ascending order (unchanged when i_a <= i_b)
//   o_gt           : i_a > i_b, i.e. a swap is required
// The compare is an (N+1)-bit subtraction of the extended operands, so the
// difference can never overflow: a > b iff the difference is nonzero and
// its sign bit is clear.
// -----------------------------------------------------------------------------
module sort4_engine_cmp_swap
  import sort4_engine_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_signed_mode,
  output logic [N-1:0] o_lo,
  output logic [N-1:0] o_hi,
  output logic         o_gt
);

  logic [N:0] w_a_ext;
  logic [N:0] w_b_ext;
  logic [N:0] w_diff;

  // Zero-extend for unsigned, sign-extend for signed.
  assign w_a_ext = {(i_signed_mode & i_a[N-1]), i_a};
  assign w_b_ext = {(i_signed_mode & i_b[N-1]), i_b};
  assign w_diff  = w_a_ext - w_b_ext;

  assign o_gt = (w_diff != {(N+1){1'b0}}) && (w_diff[N] == 1'b0);
  assign o_lo = o_gt ? i_b : i_a;
  assign o_hi = o_gt ? i_a : i_b;

endmodule

// File: rtl/sort4_engine.sv
// -----------------------------------------------------------------------------
// sort4_engine
// Sequential four-element sorter. Operands are latched on an accepted start
// and ordered ascending by six fixed bubble-sort compare/swap steps, one per
// clock, through a single shared cmp_swap unit.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (aborts any sort in flight)
//   bus  : sort4_engine_if.slave (start, signed_mode, x0..x3 in;
//          s0..s3, busy, done out)
// Start-to-done latency is 7 cycles; a start in the DONE cycle launches the
// next sort back-to-back. s0..s3 show intermediate values while busy.
// -----------------------------------------------------------------------------
module sort4_engine
  import sort4_engine_pkg::*;
#(
  parameter int N = 6
) (
  input  logic              clk,
  input  logic              rst,
  sort4_engine_if.slave     bus
);

  state_t       r_state;
  state_t       w_next_state;
  logic [2:0]   r_step;
  logic         r_mode;
  logic         r_busy;
  logic         r_done;
  logic [N-1:0] r_s [4];

  logic         w_load;
  logic         w_swap;
  logic [1:0]   w_lo_idx;
  logic [1:0]   w_hi_idx;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [N-1:0] w_lo;
  logic [N-1:0] w_hi;
  logic         w_gt;

  // Route the pair selected by the current step through the shared comparator.
  assign w_lo_idx = pair_lo(r_step);
  assign w_hi_idx = w_lo_idx + 2'd1;
  assign w_a      = r_s[w_lo_idx];
  assign w_b      = r_s[w_hi_idx];

  sort4_engine_cmp_swap #(.N(N)) u_cmp_swap (
    .i_a           (w_a),
    .i_b           (w_b),
    .i_signed_mode (r_mode),
    .o_lo          (w_lo),
    .o_hi          (w_hi),
    .o_gt          (w_gt)
  );

  // Only write the pair when it is really out of order, so equal operands
  // stay put (stable sort, no redundant register activity).
  assign w_swap = (r_state == SORT) && w_gt;

  // Next-state decode; DONE accepts a new start exactly like IDLE.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_next_state = SORT;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SORT: begin
        if (r_step == STEP_LAST) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SORT;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Step counter: cleared on load, advances once per SORT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 3'd0;
    end else if (w_load) begin
      r_step <= 3'd0;
    end else if (r_state == SORT) begin
      r_step <= (r_step == STEP_LAST) ? 3'd0 : (r_step + 3'd1);
    end else begin
      r_step <= r_step;
    end
  end

  // Operand/result registers and latched ordering mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s[0] <= {N{1'b0}};
      r_s[1] <= {N{1'b0}};
      r_s[2] <= {N{1'b0}};
      r_s[3] <= {N{1'b0}};
      r_mode <= 1'b0;
    end else if (w_load) begin
      r_s[0] <= bus.x0;
      r_s[1] <= bus.x1;
      r_s[2] <= bus.x2;
      r_s[3] <= bus.x3;
      r_mode <= bus.signed_mode;
    end else if (w_swap) begin
      r_s[w_lo_idx] <= w_lo;
      r_s[w_hi_idx] <= w_hi;
    end else begin
      r_mode <= r_mode;
    end
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == SORT);
      r_done <= (w_next_state == DONE);
    end
  end

  assign bus.s0   = r_s[0];
  assign bus.s1   = r_s[1];
  assign bus.s2   = r_s[2];
  assign bus.s3   = r_s[3];
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_sort4_engine.sv
// -----------------------------------------------------------------------------
// tb_sort4_engine
// Self-checking bench for sort4_engine: directed cases plus randomized sorts
// compared against a reference sort computed on integer keys.
// Operand sets are packed with element i at bits [6*i +: 6].
// -----------------------------------------------------------------------------
module tb_sort4_engine;
  import sort4_engine_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sort4_engine_if #(.N(6)) bus ();

  sort4_engine #(.N(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack4(input logic [5:0] a0, input logic [5:0] a1,
                                        input logic [5:0] a2, input logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference: interpret each element as an integer under the mode, then
  // repeatedly pull out the smallest remaining element.
  function automatic logic [23:0] ref_sort(input logic [23:0] xin, input bit m);
    logic [5:0]  v [4];
    int          k [4];
    bit          used [4];
    logic [23:0] o;
    o = 24'd0;
    for (int i = 0; i < 4; i++) begin
      v[i]    = xin[i*6 +: 6];
      k[i]    = m ? int'($signed(v[i])) : int'(v[i]);
      used[i] = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      int best;
      best = -1;
      for (int i = 0; i < 4; i++) begin
        if (!used[i] && (best < 0 || k[i] < k[best])) best = i;
      end
      used[best] = 1'b1;
      o[p*6 +: 6] = v[best];
    end
    return o;
  endfunction

  function automatic logic [23:0] s_now();
    return {bus.s3, bus.s2, bus.s1, bus.s0};
  endfunction

  task automatic drive(input logic [23:0] xin, input bit m);
    bus.x0 = xin[5:0];
    bus.x1 = xin[11:6];
    bus.x2 = xin[17:12];
    bus.x3 = xin[23:18];
    bus.signed_mode = m;
  endtask

  // Call at a falling edge. Launches one sort and follows it to done.
  // With scramble set, start stays high and operands/mode keep changing
  // during the sort; the task then returns with start still high.
  task automatic run_sort(input string tag, input logic [23:0] xin, input bit m,
                          input logic [23:0] exp, input bit scramble, output bit changed);
    int lat;
    int busy_cnt;
    bus.start = 1'b1;
    drive(xin, m);
    lat      = 0;
    busy_cnt = 0;
    changed  = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (s_now() !== xin) changed = 1'b1;
      if (scramble) begin
        drive(24'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({tag, "_lat"}, lat, 7);
    chk({tag, "_busycyc"}, busy_cnt, 6);
    chk({tag, "_s"}, {8'd0, s_now()}, {8'd0, exp});
    chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic done_low(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    bit          ch;
    int          done_seen;
    logic [23:0] xr;
    bit          mr;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    drive(24'd0, 1'b0);

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_s", {8'd0, s_now()}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned basic
    run_sort("basic", pack4(6'd5, 6'd3, 6'd7, 6'd1), 1'b0, pack4(6'd1, 6'd3, 6'd5, 6'd7), 1'b0, ch);
    done_low("basic");

    // Same operands, signed vs unsigned ordering
    run_sort("signed", pack4(6'h3F, 6'h02, 6'h20, 6'h00), 1'b1,
             pack4(6'h20, 6'h3F, 6'h00, 6'h02), 1'b0, ch);
    done_low("signed");
    run_sort("unsigned", pack4(6'h3F, 6'h02, 6'h20, 6'h00), 1'b0,
             pack4(6'h00, 6'h02, 6'h20, 6'h3F), 1'b0, ch);
    done_low("unsigned");

    // Extremes
    run_sort("sext", pack4(6'h1F, 6'h20, 6'h1F, 6'h20), 1'b1,
             pack4(6'h20, 6'h20, 6'h1F, 6'h1F), 1'b0, ch);
    done_low("sext");
    run_sort("uext", pack4(6'h3F, 6'h00, 6'h3F, 6'h00), 1'b0,
             pack4(6'h00, 6'h00, 6'h3F, 6'h3F), 1'b0, ch);
    done_low("uext");

    // Equal operands: no register change during the sort
    run_sort("equal", pack4(6'd4, 6'd4, 6'd4, 6'd4), 1'b0, pack4(6'd4, 6'd4, 6'd4, 6'd4), 1'b0, ch);
    chk("equal_nochange", {31'd0, ch}, 32'd0);
    done_low("equal");

    // Reverse and already sorted
    run_sort("reverse", pack4(6'd63, 6'd62, 6'd1, 6'd0), 1'b0, pack4(6'd0, 6'd1, 6'd62, 6'd63), 1'b0, ch);
    done_low("reverse");
    run_sort("sorted", pack4(6'd2, 6'd9, 6'd30, 6'd61), 1'b0, pack4(6'd2, 6'd9, 6'd30, 6'd61), 1'b0, ch);
    done_low("sorted");

    // start held with changing operands, then back-to-back launch in DONE
    run_sort("held", pack4(6'd40, 6'd10, 6'd30, 6'd20), 1'b0,
             pack4(6'd10, 6'd20, 6'd30, 6'd40), 1'b1, ch);
    run_sort("b2b", pack4(6'h3E, 6'h01, 6'h21, 6'h10), 1'b1,
             pack4(6'h21, 6'h3E, 6'h01, 6'h10), 1'b0, ch);
    done_low("b2b");

    // Asynchronous reset in the middle of a sort (step register at 3)
    bus.start = 1'b1;
    drive(pack4(6'd9, 6'd8, 6'd7, 6'd6), 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s", {8'd0, s_now()}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    run_sort("after_rst", pack4(6'd9, 6'd8, 6'd7, 6'd6), 1'b0, pack4(6'd6, 6'd7, 6'd8, 6'd9), 1'b0, ch);
    done_low("after_rst");

    // Randomized sorts against the reference
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 5))
          0:       xr[i*6 +: 6] = 6'h00;
          1:       xr[i*6 +: 6] = 6'h3F;
          2:       xr[i*6 +: 6] = 6'h20;
          3:       xr[i*6 +: 6] = 6'h1F;
          default: xr[i*6 +: 6] = 6'($urandom_range(0, 63));
        endcase
      end
      mr = 1'($urandom_range(0, 1));
      run_sort("rand", xr, mr, ref_sort(xr, mr), 1'b0, ch);
      if ($urandom_range(0, 1) == 0) begin
        done_low("rand");
      end else begin
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
